imm_gen_pipe: RTL and testbench

Parametrised, pipelined successor of the combinational immediate generator/sign extender. It decodes all five RISC-V immediate formats (I, S, B, J, U) from instruction bits [31:7] and extends the result to XLEN. Sign or zero extension is selectable. Results pass through an elastic valid/ready register pipeline of configurable depth. It sits between the decode stage and the execute stage of the pipelined core, and carries a tag through unchanged.

---
 rtl/imm_gen_pipe_pkg.sv | 15 +
 rtl/imm_gen_pipe_slice.sv | 30 +++
 rtl/imm_gen_pipe.sv | 71 +++++++
 tb/tb_imm_gen_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// imm_defs: format encodings and field widths shared by the immediate generator pipeline.
package imm_defs;
    localparam int SRC_W = 3;
    localparam int INM_W = 25;
    typedef enum logic [SRC_W-1:0] {
        SRC_I = 3'b000,
        SRC_S = 3'b001,
        SRC_B = 3'b010,
        SRC_J = 3'b011,
        SRC_U = 3'b100
    } src_e;
    function automatic logic is_illegal(input logic [SRC_W-1:0] src);
        return src > SRC_U;
    endfunction
endpackage

// File: rtl/imm_gen_pipe_slice.sv
// imm_pipe_slice: one elastic register slice; accepts when empty or when its own entry leaves.
module imm_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    assign in_ready  = !valid_q || out_ready;
    assign valid_d   = in_ready ? in_valid : valid_q;
    assign data_d    = (in_ready && in_valid) ? in_data : data_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes RISC-V I/S/B/J/U immediates, extends to XLEN and carries them
// with src/tag/illegal through STAGES elastic slices; counts accepted illegal formats.
module imm_gen_pipe
    import imm_defs::*;
#(
    parameter int XLEN     = 32,
    parameter int STAGES   = 2,
    parameter int SIGN_EXT = 1,
    parameter int TAG_W    = 5,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INM_W-1:0] in_inm,
    input  logic [SRC_W-1:0] in_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [SRC_W-1:0] out_src,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int P = XLEN + SRC_W + TAG_W + 1;
    logic            sgn, ill;
    logic [XLEN-1:0] fill, u_imm, imm;
    logic [P-1:0]    dat [STAGES+1];
    logic            vld [STAGES+1];
    logic            rdy [STAGES+1];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        sgn   = (SIGN_EXT != 0) && in_inm[24];
        ill   = is_illegal(in_src);
        fill  = {XLEN{sgn}};
        u_imm = fill;
        u_imm[31:0] = {in_inm[24:5], 12'b0};
        imm = (in_src == SRC_I) ? {fill[XLEN-1:12], in_inm[24:13]} :
              (in_src == SRC_S) ? {fill[XLEN-1:12], in_inm[24:18], in_inm[4:0]} :
              (in_src == SRC_B) ? {fill[XLEN-1:13], in_inm[24], in_inm[0], in_inm[23:18], in_inm[4:1], 1'b0} :
              (in_src == SRC_J) ? {fill[XLEN-1:21], in_inm[24], in_inm[12:5], in_inm[13], in_inm[23:14], 1'b0} :
              (in_src == SRC_U) ? u_imm : '0;
    end
    assign dat[0]      = {imm, in_src, in_tag, ill};
    assign vld[0]      = in_valid;
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;
    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        imm_pipe_slice #(.W(P)) u_slice (
            .clk      (clk),
            .reset    (reset),
            .in_valid (vld[i]),
            .in_ready (rdy[i]),
            .in_data  (dat[i]),
            .out_valid(vld[i+1]),
            .out_ready(rdy[i+1]),
            .out_data (dat[i+1])
        );
    end
    assign out_valid = vld[STAGES];
    assign {out_imm, out_src, out_tag, out_illegal} = dat[STAGES];
    // Saturate rather than wrap so a stuck-high count stays visible.
    assign cnt_d = (in_valid && rdy[0] && ill && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    assign illegal_cnt = cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving four parameter variants of imm_gen_pipe in lockstep.
module tb_imm_gen_pipe;
    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [24:0] in_inm = '0;
    logic [2:0]  in_src = '0;
    logic [4:0]  in_tag = '0;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [2:0]  out_src;
    logic [4:0]  out_tag;
    logic [7:0]  illegal_cnt;
    logic        z_in_ready, z_out_valid, z_out_illegal;
    logic [31:0] z_out_imm;
    logic [2:0]  z_out_src;
    logic [4:0]  z_out_tag;
    logic [7:0]  z_cnt;
    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_out_imm;
    logic [2:0]  w_out_src;
    logic [4:0]  w_out_tag;
    logic [7:0]  w_cnt;
    logic        c_in_ready, c_out_valid, c_out_illegal;
    logic [31:0] c_out_imm;
    logic [2:0]  c_out_src;
    logic [4:0]  c_out_tag;
    logic [1:0]  c_cnt;
    always #5 clk = ~clk;
    imm_gen_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_inm(in_inm),
        .in_src(in_src), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_src(out_src), .out_tag(out_tag), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt));
    imm_gen_pipe #(.SIGN_EXT(0)) dut_z (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(z_in_ready), .in_inm(in_inm),
        .in_src(in_src), .in_tag(in_tag), .out_valid(z_out_valid), .out_ready(out_ready),
        .out_imm(z_out_imm), .out_src(z_out_src), .out_tag(z_out_tag), .out_illegal(z_out_illegal),
        .illegal_cnt(z_cnt));
    imm_gen_pipe #(.XLEN(64)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready), .in_inm(in_inm),
        .in_src(in_src), .in_tag(in_tag), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_imm(w_out_imm), .out_src(w_out_src), .out_tag(w_out_tag), .out_illegal(w_out_illegal),
        .illegal_cnt(w_cnt));
    imm_gen_pipe #(.CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready), .in_inm(in_inm),
        .in_src(in_src), .in_tag(in_tag), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_imm(c_out_imm), .out_src(c_out_src), .out_tag(c_out_tag), .out_illegal(c_out_illegal),
        .illegal_cnt(c_cnt));
    typedef struct {
        logic [63:0] e32, e32z, e64;
        logic [2:0]  src;
        logic [4:0]  tag;
        logic        ill;
        int          acc;
        bit          exact;
    } exp_t;
    exp_t q[$];
    int total = 0, bad = 0, cyc = 0, n_acc = 0, exp_cnt = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(posedge clk) cyc <= cyc + 1;
    // Caller is at a negedge; returns at the negedge following the handshake edge.
    task automatic send(input logic [2:0] src, input logic [24:0] inm, input logic [4:0] tag,
                        input logic [63:0] e32, input logic [63:0] e32z, input logic [63:0] e64,
                        input bit exact);
        exp_t e;
        bit   hs, done;
        done = 0;
        in_valid = 1; in_src = src; in_inm = inm; in_tag = tag;
        for (int k = 0; k < 50 && !done; k++) begin
            #1 hs = in_ready;
            @(negedge clk);
            if (hs) begin
                e.e32 = e32; e.e32z = e32z; e.e64 = e64; e.src = src; e.tag = tag;
                e.ill = (src >= 3'd5); e.acc = cyc; e.exact = exact;
                q.push_back(e);
                n_acc++;
                if (src >= 3'd5) exp_cnt++;
                done = 1;
            end
        end
        if (!done) chk("send_timeout", {63'b0, in_ready}, 64'd1);
    endtask
    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
        chk("drain_left", q.size(), 0);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid) begin
                if (q.size() == 0) chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
                else begin
                    e = q[0];
                    chk("imm32", out_imm, e.e32);
                    chk("imm32_zext", z_out_imm, e.e32z);
                    chk("imm64", w_out_imm, e.e64);
                    chk("imm32_cnt2", c_out_imm, e.e32);
                    chk("src", out_src, e.src);
                    chk("tag", out_tag, e.tag);
                    chk("illegal", out_illegal, e.ill);
                    chk("valid_lockstep", {z_out_valid, w_out_valid, c_out_valid}, 3'b111);
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (e.exact) chk("latency", cyc + 1 - e.acc, 2);
                    end
                end
            end
        end
    end
    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_cnt", illegal_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1;
        send(3'd0, 25'h1FFE001, 5'd1, 64'hFFFFFFFF, 64'h00000FFF, 64'hFFFFFFFFFFFFFFFF, 1);
        send(3'd1, 25'h1FC225C, 5'd2, 64'hFFFFFFFC, 64'h00000FFC, 64'hFFFFFFFFFFFFFFFC, 0);
        send(3'd2, 25'h1FC001D, 5'd3, 64'hFFFFFFFC, 64'h00001FFC, 64'hFFFFFFFFFFFFFFFC, 0);
        send(3'd3, 25'h0002000, 5'd4, 64'h00000800, 64'h00000800, 64'h0000000000000800, 0);
        send(3'd4, 25'h02468A1, 5'd5, 64'h12345000, 64'h12345000, 64'h0000000012345000, 0);
        send(3'd4, 25'h1000001, 5'd6, 64'h80000000, 64'h80000000, 64'hFFFFFFFF80000000, 0);
        send(3'd5, 25'h1FFFFFF, 5'd7, 64'h0, 64'h0, 64'h0, 0);
        in_valid = 0;
        drain();
        chk("cnt_one", illegal_cnt, exp_cnt);
        chk("cnt_one_val", exp_cnt, 1);
        out_ready = 0;
        n_acc = 0;
        fork
            begin
                for (int t = 1; t <= 5; t++)
                    send(3'd0, {12'(t), 13'h0}, 5'(t), 64'(t), 64'(t), 64'(t), 0);
                in_valid = 0;
            end
            begin
                repeat (5) @(negedge clk);
                #1;
                chk("bp_in_ready", in_ready, 0);
                chk("bp_accepts", n_acc, 2);
                @(negedge clk);
                out_ready = 1;
            end
        join
        drain();
        for (int k = 0; k < 6; k++)
            send(3'(5 + k % 3), 25'(k * 32'h12345), 5'(10 + k), 64'h0, 64'h0, 64'h0, 0);
        in_valid = 0;
        drain();
        chk("cnt_seven", illegal_cnt, exp_cnt);
        chk("cnt2_sat", c_cnt, (exp_cnt > 3) ? 3 : exp_cnt);
        out_ready = 0;
        send(3'd5, 25'h0000123, 5'd20, 64'h0, 64'h0, 64'h0, 0);
        send(3'd6, 25'h0000456, 5'd21, 64'h0, 64'h0, 64'h0, 0);
        in_valid = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        q.delete();
        exp_cnt = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_cnt", illegal_cnt, exp_cnt);
        chk("mid_rst_cnt2", c_cnt, exp_cnt);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1;
        repeat (8) @(negedge clk);
        send(3'd0, 25'h1FFE001, 5'd9, 64'hFFFFFFFF, 64'h00000FFF, 64'hFFFFFFFFFFFFFFFF, 0);
        in_valid = 0;
        drain();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
